// File: rtl/if_stage_if.sv
// Fetch-stage bus: control and imem-load inputs plus the instruction bus consumed by decode.
// The master modport is the fetch stage; the slave modport is the controller/decoder side.
interface if_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        output instruction, pc_out, pc_plus4, valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        input  instruction, pc_out, pc_plus4, valid, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, word-addressed instruction memory with a
// load port, and one registered fetch per cycle with stall and flushing redirect.
module if_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    if_stage_if.master     io_bus
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] r_imem [IMEM_DEPTH];

    logic [31:0] r_pc_p0;
    logic [31:0] r_instr_p1;
    logic [31:0] r_pc_p1;
    logic [31:0] r_pc_plus4_p1;
    logic        r_vld_p1;
    logic [31:0] r_fetch_count;

    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic [31:0]   w_pc_next;
    logic          w_unused_bits;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign w_rd_idx  = r_pc_p0[AW+1:2];
    assign w_wr_idx  = io_bus.imem_waddr[AW+1:2];
    assign w_pc_next = r_pc_p0 + 32'd4;

    // Address bits outside the word index are deliberately ignored.
    assign w_unused_bits = ^{io_bus.imem_waddr[31:AW+2], io_bus.imem_waddr[1:0],
                             io_bus.redirect_pc[1:0]};

    // Load port is independent of rst/stall/redirect; reads see old data on a collision.
    always_ff @(posedge clk) begin
        if (io_bus.imem_we)
            r_imem[w_wr_idx] <= io_bus.imem_wdata;
    end

    // p0 -> p1: fetch at the current PC, or flush/hold per rst > redirect > stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_p0       <= RESET_PC;
            r_instr_p1    <= 32'h0000_0000;
            r_pc_p1       <= 32'h0000_0000;
            r_pc_plus4_p1 <= 32'h0000_0000;
            r_vld_p1      <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else if (io_bus.redirect) begin
            r_pc_p0       <= word_align(io_bus.redirect_pc);
            r_instr_p1    <= 32'h0000_0000;
            r_pc_p1       <= 32'h0000_0000;
            r_pc_plus4_p1 <= 32'h0000_0000;
            r_vld_p1      <= 1'b0;
        end else if (!io_bus.stall) begin
            r_pc_p0       <= w_pc_next;
            r_instr_p1    <= r_imem[w_rd_idx];
            r_pc_p1       <= r_pc_p0;
            r_pc_plus4_p1 <= w_pc_next;
            r_vld_p1      <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign io_bus.instruction = r_instr_p1;
    assign io_bus.pc_out      = r_pc_p1;
    assign io_bus.pc_plus4    = r_pc_plus4_p1;
    assign io_bus.valid       = r_vld_p1;
    assign io_bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: program load, sequential fetch, stall, redirect, write
// collision, address aliasing/wrap and mid-stream reset.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    if_stage_if bus ();

    if_stage #(.IMEM_DEPTH(256), .RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic v, input logic [31:0] cnt, input logic [31:0] p4);
        chk({tag, ".pc_out"}, bus.pc_out, pc);
        chk({tag, ".instr"}, bus.instruction, ins);
        chk({tag, ".valid"}, {31'b0, bus.valid}, {31'b0, v});
        chk({tag, ".count"}, bus.fetch_count, cnt);
        chk({tag, ".plus4"}, bus.pc_plus4, p4);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = addr;
        bus.imem_wdata = data;
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_we     = 1'b0;
        bus.imem_waddr  = 32'h0;
        bus.imem_wdata  = 32'h0;

        // Program load while held in reset.
        wr(32'h0, 32'h2001_0005); step();
        chk_out("reset", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
        wr(32'h4, 32'h2002_000A); step();
        wr(32'h8, 32'h0022_1820); step();
        wr(32'hC, 32'hAC03_0010); step();
        wr(32'h3FC, 32'h0800_0000); step();
        bus.imem_we = 1'b0;
        rst = 1'b0;

        step(); chk_out("seq0", 32'h0, 32'h2001_0005, 1'b1, 32'd1, 32'h4);
        step(); chk_out("seq1", 32'h4, 32'h2002_000A, 1'b1, 32'd2, 32'h8);

        bus.stall = 1'b1;
        step(); chk_out("stall0", 32'h4, 32'h2002_000A, 1'b1, 32'd2, 32'h8);
        step(); chk_out("stall1", 32'h4, 32'h2002_000A, 1'b1, 32'd2, 32'h8);
        step(); chk_out("stall2", 32'h4, 32'h2002_000A, 1'b1, 32'd2, 32'h8);
        bus.stall = 1'b0;
        step(); chk_out("seq2", 32'h8, 32'h0022_1820, 1'b1, 32'd3, 32'hC);

        // Redirect with stall: stall ignored, low address bits dropped.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0003; bus.stall = 1'b1;
        step(); chk_out("bubble0", 32'h0, 32'h0, 1'b0, 32'd3, 32'h0);
        bus.redirect = 1'b0; bus.stall = 1'b0;
        step(); chk_out("tgt0", 32'h0, 32'h2001_0005, 1'b1, 32'd4, 32'h4);

        // Write word 1 while it is being read: old contents returned.
        wr(32'h4, 32'hFFFF_0000);
        step(); chk_out("rbw", 32'h4, 32'h2002_000A, 1'b1, 32'd5, 32'h8);
        bus.imem_we = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h4;
        step(); chk_out("bubble1", 32'h0, 32'h0, 1'b0, 32'd5, 32'h0);
        bus.redirect = 1'b0;
        step(); chk_out("newword", 32'h4, 32'hFFFF_0000, 1'b1, 32'd6, 32'h8);

        // Aliasing: 0x400 maps to word 0.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0400;
        step(); chk_out("bubble2", 32'h0, 32'h0, 1'b0, 32'd6, 32'h0);
        bus.redirect = 1'b0;
        step(); chk_out("alias", 32'h400, 32'h2001_0005, 1'b1, 32'd7, 32'h404);

        // PC wrap at the top of the address space.
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        step(); chk_out("bubble3", 32'h0, 32'h0, 1'b0, 32'd7, 32'h0);
        bus.redirect = 1'b0;
        step(); chk_out("wrap0", 32'hFFFF_FFFC, 32'h0800_0000, 1'b1, 32'd8, 32'h0);
        step(); chk_out("wrap1", 32'h0, 32'h2001_0005, 1'b1, 32'd9, 32'h4);

        // Reset beats redirect and stall; memory survives.
        rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.stall = 1'b1;
        step(); chk_out("midrst", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
        rst = 1'b0; bus.redirect = 1'b0; bus.stall = 1'b0;
        step(); chk_out("postrst", 32'h0, 32'h2001_0005, 1'b1, 32'd1, 32'h4);
        step(); chk_out("postrst1", 32'h4, 32'hFFFF_0000, 1'b1, 32'd2, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
